// File: rtl/bbx_chk.sv
// Golden bounding-box checker that sits beside the bbox stage.
// Expected boxes are computed at R10, queued in flight, and compared with the DUT box at R13.
module bbx_chk #(
  parameter int SIGFIG  = 24,
  parameter int RADIX   = 10,
  parameter int VERTS   = 3,
  parameter int AXIS    = 3,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R10S,
  input  logic                                          validTri_R10H,
  input  logic signed [1:0][1:0][SIGFIG-1:0]            box_R13S,
  input  logic                                          validTri_R13H,
  input  logic                                          halt_RnnnnL,
  input  logic signed [1:0][SIGFIG-1:0]                 screen_RnnnnS,
  input  logic [3:0]                                    subSample_RnnnnU,
  output logic                                          err_o,
  output logic [2:0]                                    err_code_o,
  output logic [1:0][1:0][SIGFIG-1:0]                   exp_box_o,
  output logic [1:0][1:0][SIGFIG-1:0]                   got_box_o,
  output logic [CNT_W-1:0]                              match_cnt_o,
  output logic [CNT_W-1:0]                              err_cnt_o,
  output logic [CNT_W-1:0]                              cull_cnt_o,
  output logic [$clog2(DEPTH):0]                        occ_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int OW  = $clog2(DEPTH) + 1;
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef logic [1:0][1:0][SIGFIG-1:0] box_t;
  typedef enum logic {ST_RUN = 1'b0, ST_FAIL = 1'b1} state_t;

  logic push;
  logic pop;
  assign push = validTri_R10H & halt_RnnnnL;
  assign pop  = validTri_R13H & halt_RnnnnL;

  // Subsample decode; an illegal select falls back to the coarsest grid.
  logic              ss_onehot;
  logic [1:0]        ss_lg2;
  logic [SIGFIG-1:0] grid_mask;
  always_comb begin
    ss_onehot = 1'b1;
    ss_lg2    = 2'd0;
    case (subSample_RnnnnU)
      4'b0001: ss_lg2 = 2'd3;
      4'b0010: ss_lg2 = 2'd2;
      4'b0100: ss_lg2 = 2'd1;
      4'b1000: ss_lg2 = 2'd0;
      default: ss_onehot = 1'b0;
    endcase
    grid_mask = {SIGFIG{1'b1}} << (RADIX - int'(ss_lg2));
  end

  // Golden box: per-axis extent, floored to the grid, clamped to the screen.
  box_t       gold_box;
  logic [1:0] cull_axis;
  logic       cull;

  for (genvar gi = 0; gi < 2; gi++) begin : g_axis
    logic signed [SIGFIG-1:0] lo;
    logic signed [SIGFIG-1:0] hi;
    logic signed [SIGFIG-1:0] lo_fl;
    logic signed [SIGFIG-1:0] hi_fl;
    logic signed [SIGFIG-1:0] lo_cl;
    logic signed [SIGFIG-1:0] hi_cl;
    logic signed [SIGFIG-1:0] scr;

    assign scr = $signed(screen_RnnnnS[gi]);

    always_comb begin
      lo = $signed(tri_R10S[0][gi]);
      hi = $signed(tri_R10S[0][gi]);
      for (int v = 1; v < VERTS; v++) begin
        if ($signed(tri_R10S[v][gi]) < lo) lo = $signed(tri_R10S[v][gi]);
        if ($signed(tri_R10S[v][gi]) > hi) hi = $signed(tri_R10S[v][gi]);
      end
      lo_fl = lo & grid_mask;
      hi_fl = hi & grid_mask;
      lo_cl = (lo_fl < 0) ? '0 : lo_fl;
      hi_cl = (hi_fl > scr) ? scr : hi_fl;
    end

    assign gold_box[0][gi] = lo_cl;
    assign gold_box[1][gi] = hi_cl;
    assign cull_axis[gi]   = (hi_cl < 0) | (lo_cl > scr);
  end

  assign cull = |cull_axis;

  // Only x and y take part; fold the remaining coordinates away.
  logic [VERTS-1:0] unused_tri_bits;
  always_comb begin
    for (int v = 0; v < VERTS; v++) unused_tri_bits[v] = ^tri_R10S[v];
  end

  // In-flight FIFO of expected boxes.
  box_t          fifo_mem [DEPTH];
  box_t          head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          fifo_empty;
  logic          fifo_full;
  logic          want_push;
  logic          do_push;
  logic          do_pop;

  assign head = fifo_mem[rd_ptr_q];

  always_comb begin
    fifo_empty = (occ_q == '0);
    fifo_full  = (occ_q == OW'(DEPTH));
    do_pop     = pop & ~fifo_empty;
    want_push  = push & ~cull;
    do_push    = want_push & (~fifo_full | do_pop);
    wr_ptr_d   = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    occ_d      = occ_q;
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr_q] <= gold_box;
  end

  // Stall watchdog: counts unhalted cycles with work queued and nothing returned.
  logic [WDW-1:0] wd_q, wd_d;
  logic           e_timeout;
  always_comb begin
    wd_d      = wd_q;
    e_timeout = 1'b0;
    if (fifo_empty || pop) begin
      wd_d = '0;
    end else if (halt_RnnnnL) begin
      if (wd_q == WDW'(TIMEOUT - 1)) begin
        e_timeout = 1'b1;
        wd_d      = '0;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
  end

  // Error sources; bit i reports error code i+1.
  logic [4:0] err_vec;
  logic       e_mismatch;
  logic [2:0] n_err;
  logic [2:0] first_code;
  assign e_mismatch = do_pop & (head != box_t'(box_R13S));
  assign err_vec    = {push & ~ss_onehot,
                       e_timeout,
                       pop & fifo_empty,
                       want_push & fifo_full & ~do_pop,
                       e_mismatch};

  always_comb begin
    n_err      = '0;
    first_code = '0;
    for (int i = 0; i < 5; i++) n_err = n_err + {2'b00, err_vec[i]};
    for (int i = 4; i >= 0; i--) begin
      if (err_vec[i]) first_code = 3'(i + 1);
    end
  end

  // Status FSM and statistics.
  state_t         state_q, state_d;
  logic [2:0]     err_code_q, err_code_d;
  box_t           exp_box_q, exp_box_d;
  box_t           got_box_q, got_box_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] cull_cnt_q, cull_cnt_d;
  logic [CNT_W:0]   err_sum;

  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    exp_box_d  = exp_box_q;
    got_box_d  = got_box_q;
    if (state_q == ST_RUN && n_err != '0) begin
      state_d    = ST_FAIL;
      err_code_d = first_code;
      if (e_mismatch) begin
        exp_box_d = head;
        got_box_d = box_t'(box_R13S);
      end
    end
  end

  always_comb begin
    match_cnt_d = match_cnt_q;
    cull_cnt_d  = cull_cnt_q;
    if (do_pop && !e_mismatch && match_cnt_q != '1) match_cnt_d = match_cnt_q + 1'b1;
    if (push && cull && cull_cnt_q != '1) cull_cnt_d = cull_cnt_q + 1'b1;
    err_sum   = {1'b0, err_cnt_q} + (CNT_W + 1)'(n_err);
    err_cnt_d = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      err_code_q  <= '0;
      exp_box_q   <= '0;
      got_box_q   <= '0;
      match_cnt_q <= '0;
      err_cnt_q   <= '0;
      cull_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      err_code_q  <= err_code_d;
      exp_box_q   <= exp_box_d;
      got_box_q   <= got_box_d;
      match_cnt_q <= match_cnt_d;
      err_cnt_q   <= err_cnt_d;
      cull_cnt_q  <= cull_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      wd_q        <= wd_d;
    end
  end

  assign err_o       = (state_q == ST_FAIL);
  assign err_code_o  = err_code_q;
  assign exp_box_o   = exp_box_q;
  assign got_box_o   = got_box_q;
  assign match_cnt_o = match_cnt_q;
  assign err_cnt_o   = err_cnt_q;
  assign cull_cnt_o  = cull_cnt_q;
  assign occ_o       = occ_q;

endmodule

// File: tb/tb_bbx_chk.sv
// Bench for bbx_chk: directed scenarios plus random traffic against a queue-based
// reference model computed from plain integer arithmetic.
module tb_bbx_chk;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 64;
  localparam int SATMAX  = 65535;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [2:0][2:0][23:0]   tri_R10S;
  logic                    validTri_R10H;
  logic [1:0][1:0][23:0]   box_R13S;
  logic                    validTri_R13H;
  logic                    halt_RnnnnL;
  logic [1:0][23:0]        screen_RnnnnS;
  logic [3:0]              subSample_RnnnnU;
  logic                    err_o;
  logic [2:0]              err_code_o;
  logic [1:0][1:0][23:0]   exp_box_o;
  logic [1:0][1:0][23:0]   got_box_o;
  logic [15:0]             match_cnt_o;
  logic [15:0]             err_cnt_o;
  logic [15:0]             cull_cnt_o;
  logic [3:0]              occ_o;

  always #5 clk = ~clk;

  bbx_chk dut (
    .clk             (clk),
    .rst             (rst),
    .tri_R10S        (tri_R10S),
    .validTri_R10H   (validTri_R10H),
    .box_R13S        (box_R13S),
    .validTri_R13H   (validTri_R13H),
    .halt_RnnnnL     (halt_RnnnnL),
    .screen_RnnnnS   (screen_RnnnnS),
    .subSample_RnnnnU(subSample_RnnnnU),
    .err_o           (err_o),
    .err_code_o      (err_code_o),
    .exp_box_o       (exp_box_o),
    .got_box_o       (got_box_o),
    .match_cnt_o     (match_cnt_o),
    .err_cnt_o       (err_cnt_o),
    .cull_cnt_o      (cull_cnt_o),
    .occ_o           (occ_o)
  );

  typedef struct {int llx; int lly; int urx; int ury;} box_t;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [95:0] mq[$];
  int          m_match, m_errcnt, m_cull, m_wd, m_code;
  bit          m_err;
  logic [95:0] m_exp, m_got;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] pk(input box_t b);
    logic [23:0] a, c, d, e;
    a = b.llx[23:0]; c = b.lly[23:0]; d = b.urx[23:0]; e = b.ury[23:0];
    return {e, d, c, a};
  endfunction

  function automatic int floor_grid(input int v, input int g);
    int r;
    r = v % g;
    if (r < 0) r += g;
    return v - r;
  endfunction

  function automatic int lower_code(input int code, input int c);
    return (code == 0 || c < code) ? c : code;
  endfunction

  // golden box of the triangle currently on the inputs; returns 1 when culled
  function automatic bit golden(output logic [95:0] b, output bit bad);
    int lg2, g, sw, sh, mnx, mxx, mny, mxy, x, y;
    box_t r;
    bad = ($countones(subSample_RnnnnU) != 1);
    lg2 = 0;
    if (!bad) begin
      if (subSample_RnnnnU[0]) lg2 = 3;
      else if (subSample_RnnnnU[1]) lg2 = 2;
      else if (subSample_RnnnnU[2]) lg2 = 1;
    end
    g  = 1 << (10 - lg2);
    sw = int'($signed(screen_RnnnnS[0]));
    sh = int'($signed(screen_RnnnnS[1]));
    mnx = int'($signed(tri_R10S[0][0])); mxx = mnx;
    mny = int'($signed(tri_R10S[0][1])); mxy = mny;
    for (int v = 1; v < 3; v++) begin
      x = int'($signed(tri_R10S[v][0]));
      y = int'($signed(tri_R10S[v][1]));
      if (x < mnx) mnx = x;
      if (x > mxx) mxx = x;
      if (y < mny) mny = y;
      if (y > mxy) mxy = y;
    end
    r.llx = floor_grid(mnx, g); if (r.llx < 0) r.llx = 0;
    r.lly = floor_grid(mny, g); if (r.lly < 0) r.lly = 0;
    r.urx = floor_grid(mxx, g); if (r.urx > sw) r.urx = sw;
    r.ury = floor_grid(mxy, g); if (r.ury > sh) r.ury = sh;
    b = pk(r);
    return (r.urx < 0) || (r.ury < 0) || (r.llx > sw) || (r.lly > sh);
  endfunction

  // advance the model by the effect of the inputs applied this cycle
  task automatic model_step();
    logic [95:0] gb, h;
    bit bad, cl, psh, pp, popped, mm;
    int sz, n, code;
    if (!rst) begin
      mq.delete();
      m_match = 0; m_errcnt = 0; m_cull = 0; m_wd = 0; m_code = 0;
      m_err = 0; m_exp = '0; m_got = '0;
      return;
    end
    psh = validTri_R10H && halt_RnnnnL;
    pp  = validTri_R13H && halt_RnnnnL;
    n = 0; code = 0; mm = 0; popped = 0; h = '0;
    sz = mq.size();
    cl = golden(gb, bad);
    if (psh && bad) begin n++; code = lower_code(code, 5); end
    if (pp) begin
      if (sz > 0) begin
        h = mq.pop_front();
        popped = 1;
        if (h != box_R13S) begin mm = 1; n++; code = lower_code(code, 1); end
        else if (m_match < SATMAX) m_match++;
      end else begin
        n++; code = lower_code(code, 3);
      end
    end
    if (psh) begin
      if (cl) begin
        if (m_cull < SATMAX) m_cull++;
      end else if (sz == DEPTH && !popped) begin
        n++; code = lower_code(code, 2);
      end else begin
        mq.push_back(gb);
      end
    end
    if (sz == 0 || pp) m_wd = 0;
    else if (halt_RnnnnL) begin
      m_wd++;
      if (m_wd == TIMEOUT) begin n++; code = lower_code(code, 4); m_wd = 0; end
    end
    if (n > 0) begin
      m_errcnt = (m_errcnt + n > SATMAX) ? SATMAX : m_errcnt + n;
      if (!m_err) begin
        m_err = 1; m_code = code;
        if (mm) begin m_exp = h; m_got = box_R13S; end
      end
    end
  endtask

  task automatic compare_all();
    check_eq("occ", occ_o, mq.size());
    check_eq("err", err_o, m_err);
    check_eq("err_code", err_code_o, m_code);
    check_eq("match_cnt", match_cnt_o, m_match);
    check_eq("err_cnt", err_cnt_o, m_errcnt);
    check_eq("cull_cnt", cull_cnt_o, m_cull);
    check_eq("exp_box", exp_box_o, m_exp);
    check_eq("got_box", got_box_o, m_got);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    validTri_R10H = 1'b0;
    validTri_R13H = 1'b0;
    halt_RnnnnL   = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    step();
    rst = 1'b1;
  endtask

  task automatic set_tri(input int x0, input int y0, input int x1, input int y1,
                         input int x2, input int y2);
    tri_R10S[0][0] = 24'(x0); tri_R10S[0][1] = 24'(y0); tri_R10S[0][2] = 24'($urandom);
    tri_R10S[1][0] = 24'(x1); tri_R10S[1][1] = 24'(y1); tri_R10S[1][2] = 24'($urandom);
    tri_R10S[2][0] = 24'(x2); tri_R10S[2][1] = 24'(y2); tri_R10S[2][2] = 24'($urandom);
  endtask

  // (100.3,50.1),(200.7,60.0),(150.0,300.9) in 14.10 fixed point
  task automatic set_ref_tri();
    set_tri(102707, 51302, 205517, 61440, 153600, 308122);
  endtask

  function automatic int rand_coord();
    return int'($urandom_range(0, 1 << 22)) - (1 << 20);
  endfunction

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    box_t ref_box, bad_box;
    logic [95:0] ref_pk, bad_pk;
    int cyc;
    ref_box = '{llx: 102656, lly: 51200, urx: 205440, ury: 308096};
    bad_box = ref_box;
    bad_box.urx = ref_box.urx + 1;
    ref_pk = pk(ref_box);
    bad_pk = pk(bad_box);

    // 1: reset with random inputs
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      validTri_R10H = 1'($urandom); validTri_R13H = 1'($urandom);
      halt_RnnnnL = 1'($urandom); subSample_RnnnnU = 4'($urandom);
      tri_R10S = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      box_R13S = {$urandom, $urandom, $urandom};
      screen_RnnnnS = {$urandom, $urandom};
      step();
    end
    check_eq("t1_occ", occ_o, 0);
    check_eq("t1_err", err_o, 0);
    check_eq("t1_cnts", {match_cnt_o, err_cnt_o, cull_cnt_o}, 0);
    rst = 1'b1;
    screen_RnnnnS[0] = 24'(1 << 20);
    screen_RnnnnS[1] = 24'(1 << 20);
    subSample_RnnnnU = 4'b0001;
    idle();
    step();

    // 2: match with three-cycle DUT latency
    set_ref_tri(); validTri_R10H = 1'b1; step();
    idle(); step(); step();
    box_R13S = ref_pk; validTri_R13H = 1'b1; step();
    idle(); step();
    check_eq("t2_match", match_cnt_o, 1);
    check_eq("t2_err", err_o, 0);
    check_eq("t2_occ", occ_o, 0);

    // 3: cull, then an output with nothing queued
    do_reset();
    set_tri(-5 * 1024, 1024, -3 * 1024, 2048, -10 * 1024, 4096);
    validTri_R10H = 1'b1; step();
    idle(); step();
    check_eq("t3_cull", cull_cnt_o, 1);
    check_eq("t3_occ", occ_o, 0);
    validTri_R13H = 1'b1; step();
    idle(); step();
    check_eq("t3_code", err_code_o, 3);

    // 4: mismatch capture, then a later match leaves the capture alone
    do_reset();
    set_ref_tri(); validTri_R10H = 1'b1; step();
    idle(); step(); step();
    box_R13S = bad_pk; validTri_R13H = 1'b1; step();
    idle(); step();
    check_eq("t4_code", err_code_o, 1);
    check_eq("t4_errcnt", err_cnt_o, 1);
    check_eq("t4_exp", exp_box_o, ref_pk);
    check_eq("t4_got", got_box_o, bad_pk);
    validTri_R10H = 1'b1; step();
    idle(); step();
    box_R13S = ref_pk; validTri_R13H = 1'b1; step();
    idle(); step();
    check_eq("t4_match", match_cnt_o, 1);
    check_eq("t4_exp_hold", exp_box_o, ref_pk);
    check_eq("t4_got_hold", got_box_o, bad_pk);

    // 5a: overflow
    do_reset();
    set_ref_tri();
    for (int i = 0; i < 9; i++) begin validTri_R10H = 1'b1; step(); end
    idle(); step();
    check_eq("t5_code", err_code_o, 2);
    check_eq("t5_occ", occ_o, 8);

    // 5b: halt suppresses the watchdog, release exposes the timeout
    do_reset();
    validTri_R10H = 1'b1; step();
    halt_RnnnnL = 1'b0;
    for (int i = 0; i < 200; i++) begin
      validTri_R10H = 1'($urandom); validTri_R13H = 1'($urandom);
      step();
    end
    check_eq("t5_halt_err", err_o, 0);
    check_eq("t5_halt_occ", occ_o, 1);
    idle();
    cyc = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (err_o) begin cyc = i; break; end
    end
    check_eq("t5_timeout_cycles", cyc, TIMEOUT);
    check_eq("t5_timeout_code", err_code_o, 4);

    // 6: simultaneous push and pop while full
    do_reset();
    set_ref_tri();
    for (int i = 0; i < 8; i++) begin validTri_R10H = 1'b1; step(); end
    box_R13S = ref_pk; validTri_R10H = 1'b1; validTri_R13H = 1'b1; step();
    idle();
    check_eq("t6_occ", occ_o, 8);
    check_eq("t6_err", err_o, 0);
    check_eq("t6_match", match_cnt_o, 1);

    // 7: random traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 199) != 0);
      halt_RnnnnL = ($urandom_range(0, 7) != 0);
      validTri_R10H = ($urandom_range(0, 1) != 0);
      validTri_R13H = ($urandom_range(0, 9) < 4);
      if ($urandom_range(0, 9) != 0) subSample_RnnnnU = 4'(1 << $urandom_range(0, 3));
      else subSample_RnnnnU = 4'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        screen_RnnnnS[0] = 24'($urandom_range(0, 1 << 21));
        screen_RnnnnS[1] = 24'($urandom_range(0, 1 << 21));
      end
      set_tri(rand_coord(), rand_coord(), rand_coord(), rand_coord(), rand_coord(), rand_coord());
      if (mq.size() > 0 && $urandom_range(0, 9) != 0) box_R13S = mq[0];
      else box_R13S = {$urandom, $urandom, $urandom};
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
